// File: rtl/stream_acc_bin.sv
// Counts '1's of the mux-adder output bitstream over 2^LOGWIN enabled samples
// and presents the count as a binary result; `define STREAM_ACC_SCALE_EN rescales by 2^LOGINUM.
module stream_acc_bin #(
    parameter int unsigned LOGWIN  = 4,
    parameter int unsigned LOGINUM = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       en,
    input  logic                       clr,
    input  logic                       in,
    output logic                       busy,
    output logic                       valid,
    output logic [LOGWIN+LOGINUM:0]    result
);

    localparam int unsigned OW = LOGWIN + LOGINUM + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t            state;
    logic [LOGWIN:0]   ones;
    logic [LOGWIN-1:0] scnt;
    logic [LOGWIN:0]   ones_nxt;
    logic [OW-1:0]     result_nxt;

    // ones is one bit wider than scnt so an all-ones window (2^LOGWIN) fits
    always_comb begin
        ones_nxt   = ones + {{LOGWIN{1'b0}}, in};
        result_nxt = '0;
`ifdef STREAM_ACC_SCALE_EN
        result_nxt = OW'(ones_nxt) << LOGINUM;
`else
        result_nxt = OW'(ones_nxt);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ones   <= '0;
            scnt   <= '0;
            result <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else if (clr) begin
            state  <= IDLE;
            ones   <= '0;
            scnt   <= '0;
            result <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        state <= ACC;
                        ones  <= '0;
                        scnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ACC: begin
                    if (en) begin
                        ones <= ones_nxt;
                        scnt <= scnt + 1'b1;
                        // last sample of the window closes it on the same edge
                        if (scnt == '1) begin
                            result <= result_nxt;
                            state  <= DONE;
                            busy   <= 1'b0;
                            valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    valid <= 1'b0;
                    ones  <= '0;
                    scnt  <= '0;
                    if (start) begin
                        state <= ACC;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
